mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive mem-stage grants allowed while fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles bus_req may wait for bus_ack before abort.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have fetch ports: fe_req in 1 read request; fe_addr in 32 address; fe_flush in 1 discard outstanding fetch; fe_gnt out 1 request accepted; fe_rvalid out 1 response valid; fe_rdata out 32 read data.
REQ-006 SHALL have mem-stage ports: mem_req in 1; mem_addr in 32; mem_write in 1; mem_wdata in 32; mem_width in 2 (00 byte, 01 half, 1x word); mem_extend in 1 sign-extend loads; mem_gnt out 1; mem_rvalid out 1; mem_rdata out 32.
REQ-007 SHALL have backend ports: bus_req out 1; bus_addr out 32; bus_write out 1; bus_wdata out 32; bus_width out 2; bus_extend out 1; bus_ack in 1 transfer done; bus_rdata in 32 valid when bus_ack=1.
REQ-008 SHALL have port timeout  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-009 SHALL implement FSM states IDLE, FE_BUSY, MEM_BUSY; exactly one transfer outstanding at a time.
REQ-010 SHALL arbitrate only in IDLE, combinationally: grant fetch if fe_req & starve_cnt==STARVE_LIMIT; else grant mem if mem_req; else grant fetch if fe_req; else no grant.
REQ-011 SHALL assert fe_gnt or mem_gnt (never both) for exactly the IDLE cycle of the grant; requester may change inputs the next cycle.
REQ-012 SHALL latch granted addr, write, wdata, width, extend into registers on the grant edge; fetch grants latch write=0, width=10, extend=0, wdata=0.
REQ-013 SHALL move IDLE->FE_BUSY or IDLE->MEM_BUSY on the grant edge and drive bus_req=1 with latched fields from the next cycle until bus_ack or abort.
REQ-014 SHALL on bus_ack in FE_BUSY/MEM_BUSY: return to IDLE, register bus_rdata into fe_rdata/mem_rdata, pulse fe_rvalid/mem_rvalid for one cycle next cycle (grant T, bus_ack earliest T+1, rvalid T+2).
REQ-015 SHALL pulse mem_rvalid for writes also (completion), with mem_rdata holding bus_rdata as received.
REQ-016 SHALL ignore bus_ack when in IDLE.
REQ-017 SHALL hold fe_rdata and mem_rdata between responses.
REQ-018 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each mem grant with fe_req=1; clear it on any fetch grant or on a mem grant with fe_req=0.
REQ-019 SHALL count busy cycles without bus_ack; when count reaches TIMEOUT, drop bus_req, go IDLE, pulse timeout and the owner's rvalid with rdata=0 next cycle; counter clears on every grant.
REQ-020 SHALL on fe_flush=1 while FE_BUSY, or in the same cycle as fe_gnt, mark the fetch cancelled: transfer completes on the bus but fe_rvalid is suppressed and fe_rdata unchanged.
REQ-021 SHALL ignore fe_flush when no fetch is outstanding; fe_flush never affects mem-stage transfers.
REQ-022 SHALL not issue a new grant in the cycle bus_ack returns the FSM to IDLE; earliest new grant is the following cycle.

Reset
REQ-023 SHALL on clk edge with reset_n=0 set state IDLE, starve_cnt=0, timeout counter=0, cancel flag=0, all outputs 0 (fe_rdata, mem_rdata, bus_addr, bus_wdata, bus_width, bus_extend included).
REQ-024 SHALL on reset mid-transfer drop bus_req the following cycle and produce no rvalid for the aborted transfer.

Verification
REQ-025 Fetch only: fe_req, fe_addr=0x100, bus_ack 2 cycles after bus_req with 0xDEADBEEF -> fe_gnt cycle 0, bus_addr=0x100, fe_rvalid one pulse, fe_rdata=0xDEADBEEF.
REQ-026 Simultaneous fe_req and mem_req (load 0x200, width 00, extend 1) -> mem_gnt first, fetch granted after mem_rvalid; bus_width=00, bus_extend=1 during mem transfer.
REQ-027 Starvation: mem_req held high, fe_req high, STARVE_LIMIT=4, bus_ack immediate -> 4 mem grants, then fe_gnt, then mem grants resume.
REQ-028 Timeout: TIMEOUT=8, bus_ack never -> bus_req high 8 cycles, then timeout pulse, mem_rvalid pulse with mem_rdata=0, FSM back to IDLE.
REQ-029 Flush: fetch granted, fe_flush pulsed in FE_BUSY, bus_ack with 0x12345678 -> no fe_rvalid, fe_rdata unchanged, next fe_req granted normally.
REQ-030 Reset mid-transfer: reset_n=0 while MEM_BUSY -> all outputs 0 next cycle, no mem_rvalid, post-reset grant behaves per REQ-025.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, mem-stage and backend bus signals of the memory port arbiter.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface mem_port_arbiter_if;
   logic        fe_req;
   logic [31:0] fe_addr;
   logic        fe_flush;
   logic        fe_gnt;
   logic        fe_rvalid;
   logic [31:0] fe_rdata;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_width;
   logic        mem_extend;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_write;
   logic [31:0] bus_wdata;
   logic [1:0]  bus_width;
   logic        bus_extend;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   logic        timeout;

   // Handshake: a grant is a one-cycle accept in IDLE; bus_req stays high until
   // bus_ack (or abort), and each response is a one-cycle rvalid pulse.
   modport master (
      output fe_req, fe_addr, fe_flush,
      output mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
      output bus_ack, bus_rdata,
      input  fe_gnt, fe_rvalid, fe_rdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      input  bus_req, bus_addr, bus_write, bus_wdata, bus_width, bus_extend,
      input  timeout
   );

   modport slave (
      input  fe_req, fe_addr, fe_flush,
      input  mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
      input  bus_ack, bus_rdata,
      output fe_gnt, fe_rvalid, fe_rdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      output bus_req, bus_addr, bus_write, bus_wdata, bus_width, bus_extend,
      output timeout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a mem-stage port onto one single-outstanding backend bus,
// with fetch anti-starvation, transfer timeout and fetch flush. STARVE_LIMIT must be >= 1.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_port_arbiter_if.slave arb,
   output logic [1:0]        dbg_state
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, FE_BUSY = 2'd1, MEM_BUSY = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          cancel_q, cancel_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          write_q, write_d;
   logic [1:0]    width_q, width_d;
   logic          extend_q, extend_d;
   logic          fe_rvalid_q, fe_rvalid_d;
   logic [31:0]   fe_rdata_q, fe_rdata_d;
   logic          mem_rvalid_q, mem_rvalid_d;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic          timeout_q, timeout_d;

   logic fe_gnt, mem_gnt, busy, done, abort, finish, fe_cancelled;

   assign busy         = (state_q != IDLE);
   assign done         = busy & arb.bus_ack;
   assign abort        = busy & ~arb.bus_ack & (tmo_cnt_q == TW'(TIMEOUT - 1));
   assign finish       = done | abort;
   assign fe_cancelled = cancel_q | arb.fe_flush;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:              if (fe_gnt) state_d = FE_BUSY;
                            else if (mem_gnt) state_d = MEM_BUSY;
         FE_BUSY, MEM_BUSY: if (finish) state_d = IDLE;
         default:           state_d = IDLE;
      endcase
   end

   // Grants are combinational in IDLE only, so the ack cycle can never also grant.
   always_comb begin
      fe_gnt  = 1'b0;
      mem_gnt = 1'b0;
      if (reset_n && state_q == IDLE) begin
         if (arb.fe_req && starve_cnt_q == SW'(STARVE_LIMIT)) fe_gnt  = 1'b1;
         else if (arb.mem_req)                                mem_gnt = 1'b1;
         else if (arb.fe_req)                                 fe_gnt  = 1'b1;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      cancel_d     = cancel_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      width_d      = width_q;
      extend_d     = extend_q;
      fe_rvalid_d  = 1'b0;
      fe_rdata_d   = fe_rdata_q;
      mem_rvalid_d = 1'b0;
      mem_rdata_d  = mem_rdata_q;
      timeout_d    = abort;

      if (fe_gnt) begin
         starve_cnt_d = '0;
         tmo_cnt_d    = '0;
         cancel_d     = arb.fe_flush;
         addr_d       = arb.fe_addr;
         wdata_d      = '0;
         write_d      = 1'b0;
         width_d      = 2'b10;
         extend_d     = 1'b0;
      end else if (mem_gnt) begin
         tmo_cnt_d    = '0;
         addr_d       = arb.mem_addr;
         wdata_d      = arb.mem_wdata;
         write_d      = arb.mem_write;
         width_d      = arb.mem_width;
         extend_d     = arb.mem_extend;
         if (!arb.fe_req)                             starve_cnt_d = '0;
         else if (starve_cnt_q != SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SW'(1);
      end

      if (busy && !finish) tmo_cnt_d = tmo_cnt_q + TW'(1);

      // A flush seen in the completing cycle still suppresses the response.
      if (state_q == FE_BUSY) begin
         cancel_d = finish ? 1'b0 : fe_cancelled;
         if (finish && !fe_cancelled) begin
            fe_rvalid_d = 1'b1;
            fe_rdata_d  = done ? arb.bus_rdata : 32'd0;
         end
      end

      if (state_q == MEM_BUSY && finish) begin
         mem_rvalid_d = 1'b1;
         mem_rdata_d  = done ? arb.bus_rdata : 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         cancel_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         width_q      <= '0;
         extend_q     <= 1'b0;
         fe_rvalid_q  <= 1'b0;
         fe_rdata_q   <= '0;
         mem_rvalid_q <= 1'b0;
         mem_rdata_q  <= '0;
         timeout_q    <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         cancel_q     <= cancel_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         width_q      <= width_d;
         extend_q     <= extend_d;
         fe_rvalid_q  <= fe_rvalid_d;
         fe_rdata_q   <= fe_rdata_d;
         mem_rvalid_q <= mem_rvalid_d;
         mem_rdata_q  <= mem_rdata_d;
         timeout_q    <= timeout_d;
      end
   end

   assign arb.fe_gnt     = fe_gnt;
   assign arb.mem_gnt    = mem_gnt;
   assign arb.bus_req    = busy;
   assign arb.bus_addr   = addr_q;
   assign arb.bus_write  = write_q;
   assign arb.bus_wdata  = wdata_q;
   assign arb.bus_width  = width_q;
   assign arb.bus_extend = extend_q;
   assign arb.fe_rvalid  = fe_rvalid_q;
   assign arb.fe_rdata   = fe_rdata_q;
   assign arb.mem_rvalid = mem_rvalid_q;
   assign arb.mem_rdata  = mem_rdata_q;
   assign arb.timeout    = timeout_q;
   assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, starvation, timeout, flush, reset.
module tb_mem_port_arbiter;
   logic       clk;
   logic       reset_n;
   logic [1:0] dbg_state;
   int         checks;
   int         errors;
   bit         exp_fe [6];

   mem_port_arbiter_if ifc ();

   mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .arb       (ifc),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      reset_n = 1'b0;
      ifc.fe_req = 0; ifc.fe_addr = 0; ifc.fe_flush = 0;
      ifc.mem_req = 0; ifc.mem_addr = 0; ifc.mem_write = 0; ifc.mem_wdata = 0;
      ifc.mem_width = 0; ifc.mem_extend = 0; ifc.bus_ack = 0; ifc.bus_rdata = 0;

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_bus_req", ifc.bus_req, 0);
      chk("rst_fe_rdata", ifc.fe_rdata, 0);
      chk("rst_mem_rdata", ifc.mem_rdata, 0);
      chk("rst_bus_addr", ifc.bus_addr, 0);
      chk("rst_timeout", ifc.timeout, 0);
      chk("rst_state", dbg_state, 0);
      @(negedge clk); reset_n = 1'b1;

      // Plain fetch, ack two cycles after bus_req
      @(negedge clk); ifc.fe_req = 1; ifc.fe_addr = 32'h100; #1;
      chk("f1_fe_gnt", ifc.fe_gnt, 1);
      chk("f1_mem_gnt", ifc.mem_gnt, 0);
      @(negedge clk); ifc.fe_req = 0; #1;
      chk("f1_bus_req", ifc.bus_req, 1);
      chk("f1_bus_addr", ifc.bus_addr, 32'h100);
      chk("f1_bus_width", ifc.bus_width, 2);
      chk("f1_gnt_busy", ifc.fe_gnt, 0);
      @(negedge clk); #1;
      chk("f1_no_rvalid", ifc.fe_rvalid, 0);
      @(negedge clk); ifc.bus_ack = 1; ifc.bus_rdata = 32'hDEADBEEF; #1;
      chk("f1_bus_req_ack", ifc.bus_req, 1);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("f1_rvalid", ifc.fe_rvalid, 1);
      chk("f1_rdata", ifc.fe_rdata, 32'hDEADBEEF);
      chk("f1_idle", ifc.bus_req, 0);
      @(negedge clk); #1;
      chk("f1_rvalid_pulse", ifc.fe_rvalid, 0);
      chk("f1_rdata_hold", ifc.fe_rdata, 32'hDEADBEEF);

      // Simultaneous fetch and sign-extending byte load: mem wins
      @(negedge clk);
      ifc.fe_req = 1; ifc.fe_addr = 32'h104;
      ifc.mem_req = 1; ifc.mem_addr = 32'h200; ifc.mem_width = 2'b00; ifc.mem_extend = 1; #1;
      chk("p_mem_gnt", ifc.mem_gnt, 1);
      chk("p_fe_gnt", ifc.fe_gnt, 0);
      @(negedge clk); ifc.mem_req = 0; ifc.bus_ack = 1; ifc.bus_rdata = 32'hFFFFFF80; #1;
      chk("p_bus_addr", ifc.bus_addr, 32'h200);
      chk("p_bus_width", ifc.bus_width, 0);
      chk("p_bus_extend", ifc.bus_extend, 1);
      chk("p_no_gnt_on_ack", ifc.fe_gnt, 0);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("p_mem_rvalid", ifc.mem_rvalid, 1);
      chk("p_mem_rdata", ifc.mem_rdata, 32'hFFFFFF80);
      chk("p_fe_gnt_after", ifc.fe_gnt, 1);
      @(negedge clk); ifc.fe_req = 0; ifc.bus_ack = 1; ifc.bus_rdata = 32'h11111111; #1;
      chk("p_fe_addr", ifc.bus_addr, 32'h104);
      chk("p_fe_width", ifc.bus_width, 2);
      chk("p_fe_extend", ifc.bus_extend, 0);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("p_fe_rvalid", ifc.fe_rvalid, 1);
      chk("p_fe_rdata", ifc.fe_rdata, 32'h11111111);
      chk("p_mem_rvalid_pulse", ifc.mem_rvalid, 0);

      // Starvation: both requesting, immediate acks, writes on the mem side
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ifc.fe_req = 1; ifc.fe_addr = 32'h700;
         ifc.mem_req = 1; ifc.mem_write = 1; ifc.mem_width = 2'b10; ifc.mem_extend = 0;
         ifc.mem_addr = 32'h800 + 32'(i * 4); ifc.mem_wdata = 32'hA5A50000 + 32'(i);
         ifc.bus_ack = 1; ifc.bus_rdata = 32'h0BADF00D; #1;
         chk("s_fe_gnt", ifc.fe_gnt, exp_fe[i]);
         chk("s_mem_gnt", ifc.mem_gnt, !exp_fe[i]);
         if (i > 0) begin
            chk("s_fe_rvalid", ifc.fe_rvalid, exp_fe[i-1]);
            chk("s_mem_rvalid", ifc.mem_rvalid, !exp_fe[i-1]);
         end
         @(negedge clk); #1;
         chk("s_bus_req", ifc.bus_req, 1);
         chk("s_bus_write", ifc.bus_write, !exp_fe[i]);
         chk("s_bus_wdata", ifc.bus_wdata, exp_fe[i] ? 32'd0 : 32'hA5A50000 + 32'(i));
         chk("s_no_gnt_busy", ifc.mem_gnt, 0);
      end
      @(negedge clk); ifc.mem_req = 0; ifc.fe_req = 0; ifc.bus_ack = 0; ifc.mem_write = 0; #1;
      chk("s_wr_rvalid", ifc.mem_rvalid, 1);
      chk("s_wr_rdata", ifc.mem_rdata, 32'h0BADF00D);
      chk("s_fe_rdata", ifc.fe_rdata, 32'h0BADF00D);

      // Timeout: bus never acks
      @(negedge clk); ifc.mem_req = 1; ifc.mem_addr = 32'h300; ifc.mem_width = 2'b01; #1;
      chk("t_mem_gnt", ifc.mem_gnt, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); ifc.mem_req = 0; #1;
         chk("t_bus_req", ifc.bus_req, 1);
         chk("t_no_timeout", ifc.timeout, 0);
      end
      @(negedge clk); #1;
      chk("t_bus_req_drop", ifc.bus_req, 0);
      chk("t_timeout", ifc.timeout, 1);
      chk("t_mem_rvalid", ifc.mem_rvalid, 1);
      chk("t_mem_rdata", ifc.mem_rdata, 0);
      chk("t_state", dbg_state, 0);
      @(negedge clk); #1;
      chk("t_timeout_pulse", ifc.timeout, 0);
      chk("t_rvalid_pulse", ifc.mem_rvalid, 0);

      // Flush during FE_BUSY
      @(negedge clk); ifc.fe_req = 1; ifc.fe_addr = 32'h400; #1;
      chk("fl_gnt", ifc.fe_gnt, 1);
      @(negedge clk); ifc.fe_req = 0; ifc.fe_flush = 1; #1;
      chk("fl_bus_req", ifc.bus_req, 1);
      @(negedge clk); ifc.fe_flush = 0; ifc.bus_ack = 1; ifc.bus_rdata = 32'h12345678; #1;
      chk("fl_bus_req_ack", ifc.bus_req, 1);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("fl_no_rvalid", ifc.fe_rvalid, 0);
      chk("fl_rdata_kept", ifc.fe_rdata, 32'h0BADF00D);
      chk("fl_idle", dbg_state, 0);
      @(negedge clk); ifc.fe_req = 1; ifc.fe_addr = 32'h500; #1;
      chk("fl_next_gnt", ifc.fe_gnt, 1);
      @(negedge clk); ifc.fe_req = 0; ifc.bus_ack = 1; ifc.bus_rdata = 32'hCAFEF00D; #1;
      chk("fl_next_addr", ifc.bus_addr, 32'h500);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("fl_next_rvalid", ifc.fe_rvalid, 1);
      chk("fl_next_rdata", ifc.fe_rdata, 32'hCAFEF00D);

      // Reset while MEM_BUSY, with a coincident ack
      @(negedge clk);
      ifc.mem_req = 1; ifc.mem_addr = 32'h600; ifc.mem_write = 1; ifc.mem_wdata = 32'h77;
      ifc.mem_width = 2'b10; #1;
      chk("r_mem_gnt", ifc.mem_gnt, 1);
      @(negedge clk); ifc.mem_req = 0; ifc.mem_write = 0; reset_n = 0;
      ifc.bus_ack = 1; ifc.bus_rdata = 32'h99; #1;
      chk("r_bus_addr_busy", ifc.bus_addr, 32'h600);
      @(negedge clk); reset_n = 1; ifc.bus_ack = 0; #1;
      chk("r_bus_req", ifc.bus_req, 0);
      chk("r_bus_addr", ifc.bus_addr, 0);
      chk("r_bus_wdata", ifc.bus_wdata, 0);
      chk("r_bus_width", ifc.bus_width, 0);
      chk("r_bus_write", ifc.bus_write, 0);
      chk("r_mem_rvalid", ifc.mem_rvalid, 0);
      chk("r_mem_rdata", ifc.mem_rdata, 0);
      chk("r_fe_rdata", ifc.fe_rdata, 0);
      @(negedge clk); #1;
      chk("r_mem_rvalid_late", ifc.mem_rvalid, 0);
      @(negedge clk); ifc.fe_req = 1; ifc.fe_addr = 32'h100; #1;
      chk("r_fe_gnt", ifc.fe_gnt, 1);
      @(negedge clk); ifc.fe_req = 0; #1;
      chk("r_fe_bus_addr", ifc.bus_addr, 32'h100);
      @(negedge clk); #1;
      @(negedge clk); ifc.bus_ack = 1; ifc.bus_rdata = 32'hDEADBEEF; #1;
      chk("r_fe_bus_req", ifc.bus_req, 1);
      @(negedge clk); ifc.bus_ack = 0; #1;
      chk("r_fe_rvalid", ifc.fe_rvalid, 1);
      chk("r_fe_rdata", ifc.fe_rdata, 32'hDEADBEEF);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
